// File: rtl/riscv_pkg.sv
// Shared RISC-V integer-pipeline definitions: register-file geometry,
// scoreboard counter width, write-back requester indices and the
// write-back request record.
package riscv_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int SB_CNT_W = 2;
    localparam int XLEN     = 32;

    // Write-back requester indices (arbiter port order)
    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Highest value a scoreboard counter can hold
    function automatic logic [SB_CNT_W-1:0] sb_cnt_max();
        return {SB_CNT_W{1'b1}};
    endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bundle of write-back requester, register-file write port and issue-stage
// scoreboard query signals for regfile_wb_sched.
interface regfile_wb_sched_if #(
    parameter int n    = 32,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_rd;
    logic [NREQ*n-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              regwrite;
    logic [5:0]        regaddrW;
    logic [n-1:0]      wdata;
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic              issue_ready;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              busy1;
    logic              busy2;
    logic              fwd1_valid;
    logic              fwd2_valid;
    logic [n-1:0]      fwd1_data;
    logic [n-1:0]      fwd2_data;

    modport slave (
        input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
        output req_ready, regwrite, regaddrW, wdata, issue_ready,
               busy1, busy2, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );

    modport master (
        output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1, rs2,
        input  req_ready, regwrite, regaddrW, wdata, issue_ready,
               busy1, busy2, fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );
endinterface

// File: rtl/regfile_wb_sched_chk.sv
// Simulation checker for the write-back scheduler: flags a register-file
// write to a register whose scoreboard counter is already zero.
module regfile_wb_sched_chk (
    input logic clock,
    input logic nreset,
    input logic underflow_i
);
    // Scoreboard underflow is a requester protocol error
    always_ff @(posedge clock) begin
        if (nreset) begin
            assert (!underflow_i)
                else $error("regfile_wb_sched: scoreboard decrement from zero");
        end
    end
endmodule

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from (last_grant+1) mod NREQ.
// The pointer only advances when the granted request is actually accepted.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] grant_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   last_q;
    logic [IW-1:0]   last_d;
    logic [IW-1:0]   gidx_s;
    logic [NREQ-1:0] grant_s;
    logic            found_s;
    int              scan_idx_s;

    // Rotating priority search starting just after the last winner
    always_comb begin
        grant_s    = {NREQ{1'b0}};
        gidx_s     = last_q;
        found_s    = 1'b0;
        scan_idx_s = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx_s = int'(last_q) + 1 + k;
            if (scan_idx_s >= NREQ) begin
                scan_idx_s = scan_idx_s - NREQ;
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!found_s && req_i[scan_idx_s]) begin
                grant_s[scan_idx_s] = 1'b1;
                gidx_s              = IW'(scan_idx_s);
                found_s             = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        last_d = accept_i ? gidx_s : last_q;
    end

    // Last-grant pointer; reset so that requester 0 wins first
    always_ff @(posedge clock) begin
        if (!nreset) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign grant_o = grant_s;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of ALU/load/muldiv writes
// onto the single register-file write port, a registered write stage and a
// per-register 2-bit scoreboard of in-flight writes for RAW stalls.
// Optional feature macro: REGFILE_WB_BYPASS_EN (forward the write-port data
// to rs1/rs2 and drop busy for the last outstanding write).
module regfile_wb_sched
    import riscv_pkg::*;
#(
    parameter int n    = 32,
    parameter int NREQ = 3
) (
    input logic               clock,
    input logic               nreset,
    regfile_wb_sched_if.slave wb
);
    logic [NREQ-1:0]     grant_s;
    logic [NREQ-1:0]     ready_s;
    logic                accept_s;
    wb_req_t             sel_s;
    logic                regwrite_q, regwrite_d;
    logic [REG_AW-1:0]   waddr_q, waddr_d;
    logic [n-1:0]        wdata_q, wdata_d;
    logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
    logic                issue_ready_s;
    logic                issue_fire_s;
    logic                underflow_s;
    logic                inc_s, dec_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clock    (clock),
        .nreset   (nreset),
        .req_i    (wb.req_valid),
        .accept_i (accept_s),
        .grant_o  (grant_s)
    );

    assign ready_s  = nreset ? grant_s : {NREQ{1'b0}};
    assign accept_s = |(ready_s & wb.req_valid);

    // Select the granted request and form the next write-port contents
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ready_s[i]) begin
                sel_s.rd   = wb.req_rd[i*REG_AW +: REG_AW];
                sel_s.data = wb.req_data[i*n +: n];
            end else begin
                sel_s = sel_s;
            end
        end
        regwrite_d = accept_s && (sel_s.rd != 5'd0);
        if (accept_s) begin
            waddr_d = sel_s.rd;
            wdata_d = sel_s.data;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // Registered write port; reset discards any captured write
    always_ff @(posedge clock) begin
        if (!nreset) begin
            regwrite_q <= 1'b0;
            waddr_q    <= {REG_AW{1'b0}};
            wdata_q    <= {n{1'b0}};
        end else begin
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign issue_ready_s = (wb.issue_rd == 5'd0)
                        || (cnt_q[wb.issue_rd] != sb_cnt_max())
                        || (regwrite_q && (waddr_q == wb.issue_rd));
    assign issue_fire_s  = wb.issue_valid && issue_ready_s && (wb.issue_rd != 5'd0);
    assign underflow_s   = regwrite_q && (cnt_q[waddr_q] == 2'd0)
                        && !(issue_fire_s && (wb.issue_rd == waddr_q));

    // Scoreboard next state: +1 on issue, -1 on write, both cancel, floor at 0
    always_comb begin
        inc_s = 1'b0;
        dec_s = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_s = issue_fire_s && (wb.issue_rd == REG_AW'(r));
            dec_s = regwrite_q && (waddr_q == REG_AW'(r));
            case ({inc_s, dec_s})
                2'b10:   cnt_d[r] = cnt_q[r] + 2'd1;
                2'b01:   cnt_d[r] = (cnt_q[r] == 2'd0) ? 2'd0 : cnt_q[r] - 2'd1;
                default: cnt_d[r] = cnt_q[r];
            endcase
            if (r == 0) begin
                cnt_d[r] = 2'd0;
            end else begin
                cnt_d[r] = cnt_d[r];
            end
        end
    end

    // Scoreboard counters
    always_ff @(posedge clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!nreset) begin
                cnt_q[r] <= 2'd0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic hit1_s, hit2_s;
    assign hit1_s        = regwrite_q && (waddr_q == wb.rs1) && (wb.rs1 != 5'd0);
    assign hit2_s        = regwrite_q && (waddr_q == wb.rs2) && (wb.rs2 != 5'd0);
    assign wb.fwd1_valid = hit1_s;
    assign wb.fwd2_valid = hit2_s;
    assign wb.fwd1_data  = hit1_s ? wdata_q : {n{1'b0}};
    assign wb.fwd2_data  = hit2_s ? wdata_q : {n{1'b0}};
    assign wb.busy1      = (wb.rs1 != 5'd0) && (cnt_q[wb.rs1] != 2'd0)
                        && !(hit1_s && (cnt_q[wb.rs1] == 2'd1));
    assign wb.busy2      = (wb.rs2 != 5'd0) && (cnt_q[wb.rs2] != 2'd0)
                        && !(hit2_s && (cnt_q[wb.rs2] == 2'd1));
`else
    assign wb.fwd1_valid = 1'b0;
    assign wb.fwd2_valid = 1'b0;
    assign wb.fwd1_data  = {n{1'b0}};
    assign wb.fwd2_data  = {n{1'b0}};
    assign wb.busy1      = (wb.rs1 != 5'd0) && (cnt_q[wb.rs1] != 2'd0);
    assign wb.busy2      = (wb.rs2 != 5'd0) && (cnt_q[wb.rs2] != 2'd0);
`endif

    assign wb.req_ready   = ready_s;
    assign wb.regwrite    = regwrite_q;
    assign wb.regaddrW    = {1'b0, waddr_q};
    assign wb.wdata       = wdata_q;
    assign wb.issue_ready = issue_ready_s;

    regfile_wb_sched_chk u_chk (
        .clock       (clock),
        .nreset      (nreset),
        .underflow_i (underflow_s)
    );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed testbench for regfile_wb_sched: reset, round-robin rotation,
// scoreboard saturation/drain, x0 writes, bypass and reset mid-operation.
module tb_regfile_wb_sched;
    import riscv_pkg::*;

    logic clock;
    logic nreset;
    int   vectors;
    int   miscompares;

    regfile_wb_sched_if #(.n(32), .NREQ(3)) bus ();

    regfile_wb_sched #(.n(32), .NREQ(3)) dut (
        .clock  (clock),
        .nreset (nreset),
        .wb     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid   = 3'b000;
        bus.req_rd      = 15'd0;
        bus.req_data    = 96'd0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.rs1         = 5'd0;
        bus.rs2         = 5'd0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        nreset = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        nreset          = 1'b0;
        bus.req_valid   = 3'b111;
        bus.req_rd      = 15'd0;
        bus.req_data    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        bus.rs1         = 5'd5;
        bus.rs2         = 5'd5;
        tick();
        tick();
        vectors++; if (bus.regwrite !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite got %b want 0", bus.regwrite); end
        vectors++; if (bus.regaddrW !== 6'd0) begin miscompares++; $display("FAIL reset_regaddrW got %h want 00", bus.regaddrW); end
        vectors++; if (bus.wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", bus.wdata); end
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
        vectors++; if ({bus.busy1, bus.busy2} !== 2'b00) begin miscompares++; $display("FAIL reset_busy got %b want 00", {bus.busy1, bus.busy2}); end
        vectors++; if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_req_ready got %b want 000", bus.req_ready); end
        vectors++; if ({bus.fwd1_valid, bus.fwd2_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_fwd_valid got %b want 00", {bus.fwd1_valid, bus.fwd2_valid}); end
        nreset          = 1'b1;
        bus.issue_valid = 1'b0;
        #1;
        vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL reset_first_grant got %b want 001", bus.req_ready); end
        bus.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [6];
        logic [4:0] exp_rd;
        exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100;
        exp_gnt[3] = 3'b001; exp_gnt[4] = 3'b010; exp_gnt[5] = 3'b100;
        apply_reset();
        // two outstanding writes each for x1, x2, x3
        bus.issue_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.issue_rd = 5'((k % 3) + 1);
            tick();
        end
        bus.issue_valid = 1'b0;
        bus.rs1 = 5'd1;
        bus.rs2 = 5'd3;
        #1;
        vectors++; if ({bus.busy1, bus.busy2} !== 2'b11) begin miscompares++; $display("FAIL rr_busy_before got %b want 11", {bus.busy1, bus.busy2}); end
        bus.req_valid = 3'b111;
        bus.req_rd    = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        #1;
        for (int k = 0; k < 6; k++) begin
            vectors++; if (bus.req_ready !== exp_gnt[k]) begin miscompares++; $display("FAIL rr_grant[%0d] got %b want %b", k, bus.req_ready, exp_gnt[k]); end
            if (k > 0) begin
                exp_rd = 5'(((k - 1) % 3) + 1);
                vectors++; if (bus.regwrite !== 1'b1 || bus.regaddrW !== {1'b0, exp_rd}) begin
                    miscompares++; $display("FAIL rr_wport[%0d] got we=%b addr=%0d want we=1 addr=%0d", k, bus.regwrite, bus.regaddrW, exp_rd);
                end
            end
            tick();
        end
        bus.req_valid = 3'b000;
        #1;
        vectors++; if (bus.regwrite !== 1'b1 || bus.regaddrW !== 6'd3 || bus.wdata !== 32'hA000_0002) begin
            miscompares++; $display("FAIL rr_last_write got we=%b addr=%0d data=%h want we=1 addr=3 data=a0000002", bus.regwrite, bus.regaddrW, bus.wdata);
        end
        tick();
        vectors++; if (bus.regwrite !== 1'b0) begin miscompares++; $display("FAIL rr_idle_regwrite got %b want 0", bus.regwrite); end
        vectors++; if ({bus.busy1, bus.busy2} !== 2'b00) begin miscompares++; $display("FAIL rr_busy_after got %b want 00", {bus.busy1, bus.busy2}); end
    endtask

    task automatic test_scoreboard();
        apply_reset();
        bus.rs1         = 5'd5;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL sb_issue_ready[%0d] got %b want 1", k, bus.issue_ready); end
            tick();
        end
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL sb_saturated got %b want 0", bus.issue_ready); end
        vectors++; if (bus.busy1 !== 1'b1) begin miscompares++; $display("FAIL sb_busy1 got %b want 1", bus.busy1); end
        bus.issue_rd = 5'd0;
        #1;
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL sb_x0_ready got %b want 1", bus.issue_ready); end
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd5;
        // first write of x5 from the mul/div unit
        bus.req_valid = 3'b100;
        bus.req_rd    = {5'd5, 5'd0, 5'd0};
        bus.req_data  = {32'h0000_0055, 64'd0};
        #1;
        vectors++; if (bus.req_ready !== 3'b100) begin miscompares++; $display("FAIL sb_grant_muldiv got %b want 100", bus.req_ready); end
        tick();
        bus.req_valid = 3'b000;
        #1;
        vectors++; if (bus.regwrite !== 1'b1 || bus.regaddrW !== 6'd5) begin miscompares++; $display("FAIL sb_write1 got we=%b addr=%0d want we=1 addr=5", bus.regwrite, bus.regaddrW); end
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL sb_ready_on_write got %b want 1", bus.issue_ready); end
        // issue and write together at count 3: count stays 3
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        #1;
        vectors++; if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL sb_hold_at_3 got %b want 0", bus.issue_ready); end
        bus.req_valid = 3'b100;
        tick();
        tick();
        tick();
        bus.req_valid = 3'b000;
        #1;
        vectors++; if (bus.regwrite !== 1'b1) begin miscompares++; $display("FAIL sb_last_write got %b want 1", bus.regwrite); end
`ifdef REGFILE_WB_BYPASS_EN
        vectors++; if (bus.busy1 !== 1'b0 || bus.fwd1_valid !== 1'b1 || bus.fwd1_data !== 32'h55) begin
            miscompares++; $display("FAIL sb_last_bypass got busy=%b fv=%b fd=%h want busy=0 fv=1 fd=55", bus.busy1, bus.fwd1_valid, bus.fwd1_data);
        end
`else
        vectors++; if (bus.busy1 !== 1'b1 || bus.fwd1_valid !== 1'b0) begin
            miscompares++; $display("FAIL sb_last_busy got busy=%b fv=%b want busy=1 fv=0", bus.busy1, bus.fwd1_valid);
        end
`endif
        tick();
        vectors++; if (bus.busy1 !== 1'b0 || bus.regwrite !== 1'b0) begin miscompares++; $display("FAIL sb_drained got busy=%b we=%b want 0 0", bus.busy1, bus.regwrite); end
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL sb_ready_drained got %b want 1", bus.issue_ready); end
    endtask

    task automatic test_x0();
        apply_reset();
        bus.rs2       = 5'd1;
        bus.req_valid = 3'b010;
        bus.req_rd    = 15'd0;
        bus.req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
        #1;
        vectors++; if (bus.req_ready !== 3'b010) begin miscompares++; $display("FAIL x0_grant got %b want 010", bus.req_ready); end
        tick();
        bus.req_valid = 3'b000;
        #1;
        vectors++; if (bus.regwrite !== 1'b0) begin miscompares++; $display("FAIL x0_regwrite got %b want 0", bus.regwrite); end
        tick();
        vectors++; if (bus.regwrite !== 1'b0 || bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
            miscompares++; $display("FAIL x0_after got we=%b b1=%b b2=%b want 0 0 0", bus.regwrite, bus.busy1, bus.busy2);
        end
        vectors++; if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL x0_issue_ready got %b want 1", bus.issue_ready); end
    endtask

    task automatic test_bypass();
        apply_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.rs2         = 5'd7;
        #1;
        vectors++; if (bus.busy2 !== 1'b1) begin miscompares++; $display("FAIL byp_busy_before got %b want 1", bus.busy2); end
        bus.req_valid = 3'b001;
        bus.req_rd    = {10'd0, 5'd7};
        bus.req_data  = {64'd0, 32'h0000_1234};
        tick();
        bus.req_valid = 3'b000;
        #1;
        vectors++; if (bus.regwrite !== 1'b1 || bus.regaddrW !== 6'd7 || bus.wdata !== 32'h1234) begin
            miscompares++; $display("FAIL byp_wport got we=%b addr=%0d data=%h want we=1 addr=7 data=1234", bus.regwrite, bus.regaddrW, bus.wdata);
        end
`ifdef REGFILE_WB_BYPASS_EN
        vectors++; if (bus.busy2 !== 1'b0 || bus.fwd2_valid !== 1'b1 || bus.fwd2_data !== 32'h1234) begin
            miscompares++; $display("FAIL byp_fwd got busy=%b fv=%b fd=%h want busy=0 fv=1 fd=1234", bus.busy2, bus.fwd2_valid, bus.fwd2_data);
        end
`else
        vectors++; if (bus.busy2 !== 1'b1 || bus.fwd2_valid !== 1'b0 || bus.fwd2_data !== 32'd0) begin
            miscompares++; $display("FAIL byp_nofwd got busy=%b fv=%b fd=%h want busy=1 fv=0 fd=0", bus.busy2, bus.fwd2_valid, bus.fwd2_data);
        end
`endif
        tick();
        vectors++; if (bus.busy2 !== 1'b0 || bus.fwd2_valid !== 1'b0) begin
            miscompares++; $display("FAIL byp_after got busy=%b fv=%b want 0 0", bus.busy2, bus.fwd2_valid);
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        tick();
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1         = 5'd9;
        bus.req_valid   = 3'b001;
        bus.req_rd      = {10'd0, 5'd9};
        bus.req_data    = {64'd0, 32'h0000_0999};
        #1;
        vectors++; if (bus.busy1 !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b want 1", bus.busy1); end
        tick();
        nreset        = 1'b0;
        bus.req_valid = 3'b000;
        tick();
        vectors++; if (bus.regwrite !== 1'b0 || bus.regaddrW !== 6'd0 || bus.wdata !== 32'd0) begin
            miscompares++; $display("FAIL mid_wport got we=%b addr=%0d data=%h want 0 0 0", bus.regwrite, bus.regaddrW, bus.wdata);
        end
        vectors++; if (bus.busy1 !== 1'b0) begin miscompares++; $display("FAIL mid_counter got busy=%b want 0", bus.busy1); end
        nreset = 1'b1;
        tick();
        vectors++; if (bus.regwrite !== 1'b0 || bus.busy1 !== 1'b0) begin
            miscompares++; $display("FAIL mid_after got we=%b busy=%b want 0 0", bus.regwrite, bus.busy1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nreset      = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_scoreboard();
        test_x0();
        test_bypass();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
